avr_bus_master: RTL and testbench
=================================

// Module: avr_bus_master
// PURPOSE
//  Initiator side of the AVR<->CPLD SRAM bus: drives the exact pin set the CPLD bridge responds to.
//  Takes one SRAM read/write request from a local master.
//  - Shifts the 21-bit address MSB-first over si/clk while sreg_en is low.
//  - Runs the ce/oe/we strobe cycle on the 8-bit data bus and returns read data.
//  Used in the FPGA test harness and as a synthesizable model of AVR firmware bus timing.
//  Skips the address shift when the address equals the last one shifted.
// PARAMETERS
//  ADDR_W     21  address bits shifted per request
//  DATA_W     8   data bus width
//  SCLK_DIV   2   clk cycles per shift-clock half period (>=1)
//  SETUP_CYC  1   cycles ce low before oe/we strobe (>=1)
//  STROBE_CYC 2   cycles oe/we held low (>=1)
//  SKIP_SAME  1   1 = omit shift when req_addr == last shifted address
// PORTS
//  clk          in    1       system clock
//  reset_n      in    1       asynchronous reset, active low
//  req_valid    in    1       request present
//  req_ready    out   1       accepting request (high only in IDLE)
//  req_write    in    1       1 = write, 0 = read
//  req_addr     in    ADDR_W  SRAM address
//  req_wdata    in    DATA_W  write data
//  rsp_valid    out   1       1-cycle pulse: request complete
//  rsp_rdata    out   DATA_W  read data; valid with rsp_valid, held until next read
//  avr_si       out   1       serial address bit
//  avr_clk      out   1       shift clock; CPLD samples avr_si on rising edge
//  avr_sreg_en  out   1       active-low shift enable
//  avr_ce       out   1       active-low chip enable
//  avr_oe       out   1       active-low output enable
//  avr_we       out   1       active-low write enable
//  avr_data     inout DATA_W  bus; driven only during write SETUP..HOLD, else Z
// BEHAVIOUR
//  Reset (async, any state):
//  - state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0.
//  - avr_si=0, avr_clk=0, avr_sreg_en=1, avr_ce=avr_oe=avr_we=1, avr_data=Z.
//  - last_valid=0 (shift cache cleared).
//  All outputs registered; no combinational path from req_* to pins.
//  Accept: req_valid&&req_ready at edge E0 latches write/addr/wdata.
//  - Next state is SHIFT.
//  - If SKIP_SAME && last_valid && addr==last_addr, next state is SETUP instead.
//  SHIFT, per bit i = ADDR_W-1 down to 0:
//  - sreg_en=0; clk low SCLK_DIV cycles with si=addr[i] set on entry; clk high SCLK_DIV cycles.
//  - si stable across the rising edge.
//  - Total ADDR_W*2*SCLK_DIV cycles (84 at default); then last_addr<=addr, last_valid<=1.
//  ADDR_DONE (1 cycle): clk=0, sreg_en=1, so the address is frozen before any strobe.
//  SETUP (SETUP_CYC cycles): ce=0; on write, drive avr_data=wdata.
//  STROBE (STROBE_CYC cycles): oe=0 (read) or we=0 (write).
//  - Read: rsp_rdata<=avr_data sampled at the last STROBE edge.
//  HOLD (1 cycle): oe=we=1; ce stays 0; write data still driven (hold time).
//  RESP (1 cycle): ce=1, avr_data=Z, rsp_valid=1, req_ready=0. Then IDLE.
//  Latency, accept edge to rsp_valid high:
//  - Full: ADDR_W*2*SCLK_DIV+SETUP_CYC+STROBE_CYC+3 = 90 at defaults.
//  - Skipped: SETUP_CYC+STROBE_CYC+2 = 5.
//  Back-to-back: req_ready returns 1 the cycle after RESP; minimum 1 idle cycle between requests.
//  req_valid ignored outside IDLE; request fields need only be valid at the accept edge.
//  Never: oe and we both low; avr_data driven while oe low; sreg_en low while ce low.
//  Reset mid-SHIFT leaves a partial address in the CPLD register.
//  - last_valid cleared, so the next request always does a full shift.
// STRUCTURE
//  Package avr_bus_pkg:
//  - state enum {IDLE,SHIFT,ADDR_DONE,SETUP,STROBE,HOLD,RESP}.
//  - Pin idle-level constants.
//  - Default ADDR_W/DATA_W.
//  Sub-module avr_shift_tx (ADDR_W, SCLK_DIV):
//  - Serializer, divider and bit counter.
//  - I/F: start, addr, done pulse, si, sclk, en_n.
//  Top holds the FSM, last-address cache and tristate.
// TESTING
//  1 Write addr=21'h1ABCDE, data=8'h5A:
//    -> CPLD-side shift model captures 21'h1ABCDE after exactly 21 rising avr_clk edges.
//    -> we low 2 cycles with avr_data=8'h5A; rsp_valid 90 cycles after accept.
//  2 Read 21'h1ABCDE, SRAM model returns 8'hC3:
//    -> no shift pulses (skip); oe low 2 cycles; rsp_rdata=8'hC3; rsp_valid 5 cycles after accept.
//  3 Read 21'h000000 then 21'h1FFFFF:
//    -> both fully shifted; si constant 0, then constant 1, for all 21 bits.
//  4 Assert reset_n=0 at shift bit 10 of 21'h0F0F0F:
//    -> pins idle that cycle, req_ready=1.
//    -> next request to 21'h0F0F0F does a full 21-bit shift.
//  5 req_valid held high for 3 requests:
//    -> each accepted only in IDLE; rsp_valid count 3; no overlap of ce windows.
//  6 Assertions across random traffic:
//    -> never oe&we both low; never sreg_en low with ce low; avr_data Z whenever oe low.

Source files
------------

// File: rtl/avr_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : avr_bus_pkg                                                  |
// | Description : Shared types and constants for the AVR<->CPLD SRAM bus      |
// |               initiator: FSM state encoding, pin idle levels and default   |
// |               bus geometry.                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package avr_bus_pkg;

  // Default bus geometry of the CPLD bridge
  localparam int DEF_ADDR_W = 21;
  localparam int DEF_DATA_W = 8;

  // Pin levels while the bus is parked
  localparam logic PIN_SI_IDLE      = 1'b0;
  localparam logic PIN_SCLK_IDLE    = 1'b0;
  localparam logic PIN_SREG_EN_IDLE = 1'b1;  // active low
  localparam logic PIN_STROBE_IDLE  = 1'b1;  // ce/oe/we, all active low

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_ADDR_DONE = 3'd2,
    ST_SETUP     = 3'd3,
    ST_STROBE    = 3'd4,
    ST_HOLD      = 3'd5,
    ST_RESP      = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/avr_shift_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : avr_shift_tx                                                 |
// | Description : MSB-first address serializer for the CPLD shift register.    |
// |               Each bit is SCLK_DIV cycles with sclk low followed by        |
// |               SCLK_DIV cycles with sclk high; si changes only at the start |
// |               of the low phase so it is stable across the rising edge.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk      in   system clock                                               |
// |   reset_n  in   asynchronous reset, active low                             |
// |   start    in   load addr and begin shifting (ignored while busy)          |
// |   addr     in   address to serialize, sampled with start                   |
// |   done     out  high during the final cycle of the last bit               |
// |   si       out  serial data (0 when idle)                                  |
// |   sclk     out  shift clock (0 when idle)                                  |
// |   en_n     out  active-low shift enable, low for the whole transfer        |
// +----------------------------------------------------------------------------+
// Outputs are decoded from flops only; the top registers them once more
// before they reach the pins.
module avr_shift_tx
  import avr_bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SCLK_DIV = 2            // >= 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic              si,
  output logic              sclk,
  output logic              en_n
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADDR_W - 1);

  logic              busy_q,  busy_d;
  logic              phase_q, phase_d;   // 0 = sclk low half, 1 = sclk high half
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [ADDR_W-1:0] sreg_q,  sreg_d;
  logic              div_end;

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    if (start && !busy_q) begin
      busy_d  = 1'b1;
      phase_d = 1'b0;
      div_d   = '0;
      bit_d   = '0;
      sreg_d  = addr;
    end else if (busy_q) begin
      if (div_end) begin
        div_d = '0;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // end of a bit: advance to the next one or finish
          phase_d = 1'b0;
          sreg_d  = sreg_q << 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            busy_d = 1'b0;
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
    end
  end

  assign done = busy_q && phase_q && div_end && (bit_q == BIT_LAST);
  assign si   = busy_q ? sreg_q[ADDR_W-1] : PIN_SI_IDLE;
  assign sclk = busy_q ? phase_q : PIN_SCLK_IDLE;
  assign en_n = ~busy_q;

endmodule
`default_nettype wire

// File: rtl/avr_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : avr_bus_master                                               |
// | Description : Initiator side of the AVR<->CPLD SRAM bus. Accepts one read  |
// |               or write request, shifts the address into the CPLD (skipped  |
// |               when it matches the last address shifted), runs the ce/oe/we |
// |               strobe cycle and returns read data.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset_n            clock, asynchronous active-low reset             |
// |   req_valid/ready         request handshake (ready only in IDLE)           |
// |   req_write/addr/wdata    request fields, sampled at the accept edge       |
// |   rsp_valid               1-cycle completion pulse                         |
// |   rsp_rdata               read data, held until the next read              |
// |   avr_si/clk/sreg_en      address shift interface to the CPLD              |
// |   avr_ce/oe/we            active-low SRAM strobes                          |
// |   avr_data                bidirectional data bus                           |
// +----------------------------------------------------------------------------+
// Every pin is a flop fed from the registered FSM state, so pins trail the
// state by one cycle. req_ready is computed from both current and next state
// so that it drops on the accept edge and stays low through the RESP pin cycle.
module avr_bus_master
  import avr_bus_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SCLK_DIV   = 2,   // >= 1
  parameter int SETUP_CYC  = 1,   // >= 1
  parameter int STROBE_CYC = 2,   // >= 1
  parameter int SKIP_SAME  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              avr_si,
  output logic              avr_clk,
  output logic              avr_sreg_en,
  output logic              avr_ce,
  output logic              avr_oe,
  output logic              avr_we,
  inout  wire  [DATA_W-1:0] avr_data
);

  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              last_valid_q, last_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // pin flops
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              si_q, si_d;
  logic              sclk_q, sclk_d;
  logic              sreg_en_q, sreg_en_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic              data_oe_q, data_oe_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic accept;
  logic addr_hit;
  logic bus_cycle;
  logic shift_start;
  logic shift_done, shift_si, shift_sclk, shift_en_n;

  assign accept = req_valid && req_ready_q;

  generate
    if (SKIP_SAME != 0) begin : g_skip
      assign addr_hit = last_valid_q && (req_addr == last_addr_q);
    end else begin : g_no_skip
      assign addr_hit = 1'b0;
    end
  endgenerate

  avr_shift_tx #(
    .ADDR_W   (ADDR_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (shift_start),
    .addr    (req_addr),
    .done    (shift_done),
    .si      (shift_si),
    .sclk    (shift_sclk),
    .en_n    (shift_en_n)
  );

  // next-state and datapath
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    rdata_d      = rdata_q;
    shift_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (addr_hit) begin
            state_d = ST_SETUP;
          end else begin
            state_d     = ST_SHIFT;
            shift_start = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d      = ST_ADDR_DONE;
          last_addr_d  = addr_q;
          last_valid_d = 1'b1;
        end
      end
      ST_ADDR_DONE: begin
        state_d = ST_SETUP;
        cnt_d   = '0;
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // This edge ends the last oe-low pin cycle: capture read data here.
        state_d = ST_RESP;
        if (!write_q) begin
          rdata_d = avr_data;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // pin decode, registered below
  always_comb begin
    bus_cycle   = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    req_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    rsp_valid_d = (state_q == ST_RESP);
    si_d        = shift_si;
    sclk_d      = shift_sclk;
    sreg_en_d   = shift_en_n;
    ce_d        = ~bus_cycle;
    oe_d        = ~((state_q == ST_STROBE) && !write_q);
    we_d        = ~((state_q == ST_STROBE) && write_q);
    data_oe_d   = bus_cycle && write_q;
    data_out_d  = wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      rdata_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      si_q         <= PIN_SI_IDLE;
      sclk_q       <= PIN_SCLK_IDLE;
      sreg_en_q    <= PIN_SREG_EN_IDLE;
      ce_q         <= PIN_STROBE_IDLE;
      oe_q         <= PIN_STROBE_IDLE;
      we_q         <= PIN_STROBE_IDLE;
      data_oe_q    <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      rdata_q      <= rdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      si_q         <= si_d;
      sclk_q       <= sclk_d;
      sreg_en_q    <= sreg_en_d;
      ce_q         <= ce_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      data_oe_q    <= data_oe_d;
      data_out_q   <= data_out_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign avr_si      = si_q;
  assign avr_clk     = sclk_q;
  assign avr_sreg_en = sreg_en_q;
  assign avr_ce      = ce_q;
  assign avr_oe      = oe_q;
  assign avr_we      = we_q;
  assign avr_data    = data_oe_q ? data_out_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_avr_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_avr_bus_master                                            |
// | Description : Self-checking bench for avr_bus_master with a CPLD shift     |
// |               register model, an SRAM model and a transaction-level        |
// |               reference model (memory contents, last shifted address).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_avr_bus_master;

  localparam int ADDR_W     = 21;
  localparam int DATA_W     = 8;
  localparam int SCLK_DIV   = 2;
  localparam int SETUP_CYC  = 1;
  localparam int STROBE_CYC = 2;
  localparam int LAT_FULL   = ADDR_W*2*SCLK_DIV + SETUP_CYC + STROBE_CYC + 3;
  localparam int LAT_SKIP   = SETUP_CYC + STROBE_CYC + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              avr_si, avr_clk, avr_sreg_en, avr_ce, avr_oe, avr_we;
  wire  [DATA_W-1:0] avr_data;

  avr_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCLK_DIV(SCLK_DIV),
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .SKIP_SAME(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .avr_si(avr_si), .avr_clk(avr_clk), .avr_sreg_en(avr_sreg_en),
    .avr_ce(avr_ce), .avr_oe(avr_oe), .avr_we(avr_we), .avr_data(avr_data)
  );

  always #5 clk = ~clk;

  // ---------------- environment: CPLD shift register + SRAM ----------------
  function automatic logic [7:0] dflt(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [ADDR_W-1:0] cpld_reg = '0;
  int                shift_edges = 0;
  logic [7:0]        sram_mem [logic [ADDR_W-1:0]];
  logic              ovr_en = 1'b0;
  logic [ADDR_W-1:0] ovr_addr = '0;
  logic [7:0]        ovr_val = '0;
  logic [7:0]        sram_q = '0;

  always @(posedge avr_clk) begin
    if (reset_n && !avr_sreg_en) begin
      cpld_reg    <= {cpld_reg[ADDR_W-2:0], avr_si};
      shift_edges <= shift_edges + 1;
    end
  end

  always @(negedge avr_oe) begin
    if (ovr_en && cpld_reg == ovr_addr) sram_q <= ovr_val;
    else if (sram_mem.exists(cpld_reg)) sram_q <= sram_mem[cpld_reg];
    else sram_q <= dflt(cpld_reg);
  end

  always @(posedge avr_we) begin
    if (reset_n && !avr_ce) sram_mem[cpld_reg] = avr_data;
  end

  assign avr_data = (!avr_ce && !avr_oe) ? sram_q : {DATA_W{1'bz}};

  // ---------------- pin monitor ----------------
  int         we_cnt = 0, oe_cnt = 0, we_bad = 0, inv_bad = 0;
  logic [7:0] mon_wd = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (!avr_we) begin
        we_cnt = we_cnt + 1;
        if (avr_data !== mon_wd) we_bad = we_bad + 1;
      end
      if (!avr_oe) begin
        oe_cnt = oe_cnt + 1;
        if (avr_data !== sram_q) inv_bad = inv_bad + 1;
      end
      if (!avr_oe && !avr_we) inv_bad = inv_bad + 1;
      if (!avr_sreg_en && !avr_ce) inv_bad = inv_bad + 1;
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One request: returns latency (edges after accept until rsp_valid),
  // read data, and the pin activity seen during the transaction.
  task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output int edges,
                        output int wec, output int oec, output int web);
    int n, e0, w0, o0, b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; mon_wd = d;
    n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    chk("accept_wait", (n >= 300) ? 1 : 0, 0);
    e0 = shift_edges; w0 = we_cnt; o0 = oe_cnt; b0 = we_bad;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = 8'($urandom);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); lat++;
      #1;
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    edges = shift_edges - e0;
    wec = we_cnt - w0; oec = oe_cnt - o0; web = we_bad - b0;
  endtask

  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic              pre_en;
    logic [7:0]        pre_v;
    int                exp_lat;
    int                exp_edges;
    logic [7:0]        exp_rd;
  } vec_t;

  vec_t              vt [4];
  logic [7:0]        ref_mem [logic [ADDR_W-1:0]];
  logic              ref_last_valid;
  logic [ADDR_W-1:0] ref_last_addr;
  logic [ADDR_W-1:0] pool [4];
  int                lat, edges, wec, oec, web;
  logic [7:0]        rd;
  logic [ADDR_W-1:0] tmp_a;

  initial begin
    vt[0] = '{1'b1, 21'h1ABCDE, 8'h5A, 1'b0, 8'h00, LAT_FULL, ADDR_W, 8'h00};
    vt[1] = '{1'b0, 21'h1ABCDE, 8'h00, 1'b1, 8'hC3, LAT_SKIP, 0,      8'hC3};
    vt[2] = '{1'b0, 21'h000000, 8'h00, 1'b0, 8'h00, LAT_FULL, ADDR_W, 8'h3C};
    vt[3] = '{1'b0, 21'h1FFFFF, 8'h00, 1'b0, 8'h00, LAT_FULL, ADDR_W, 8'h3C};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_pins", {24'h0, req_ready, rsp_valid, avr_si, avr_clk, avr_sreg_en,
                       avr_ce, avr_oe, avr_we}, 32'h8F);
    chk("reset_rdata", {24'h0, rsp_rdata}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_pins", {24'h0, req_ready, rsp_valid, avr_si, avr_clk, avr_sreg_en,
                      avr_ce, avr_oe, avr_we}, 32'h8F);

    // directed table: write, skipped read, all-zero and all-one addresses
    for (int i = 0; i < 4; i++) begin
      ovr_en = vt[i].pre_en; ovr_addr = vt[i].a; ovr_val = vt[i].pre_v;
      do_req(vt[i].w, vt[i].a, vt[i].d, lat, rd, edges, wec, oec, web);
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_shift_edges", i), edges, vt[i].exp_edges);
      chk($sformatf("v%0d_cpld_addr", i), {11'h0, cpld_reg}, {11'h0, vt[i].a});
      if (vt[i].w) begin
        chk($sformatf("v%0d_we_cycles", i), wec, STROBE_CYC);
        chk($sformatf("v%0d_oe_cycles", i), oec, 0);
        chk($sformatf("v%0d_wdata_bad", i), web, 0);
      end else begin
        chk($sformatf("v%0d_oe_cycles", i), oec, STROBE_CYC);
        chk($sformatf("v%0d_we_cycles", i), wec, 0);
        chk($sformatf("v%0d_rdata", i), {24'h0, rd}, {24'h0, vt[i].exp_rd});
      end
    end
    ovr_en = 1'b0;
    tmp_a = 21'h1ABCDE;
    chk("sram_written", sram_mem.exists(tmp_a) ? {24'h0, sram_mem[tmp_a]} : 32'hFFFF, 32'h5A);

    // reset in the middle of a shift
    tmp_a = 21'h0F0F0F;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = tmp_a;
    begin
      int n, e0;
      n = 0;
      while (!req_ready && n < 300) begin @(negedge clk); n++; end
      e0 = shift_edges;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while ((shift_edges - e0) < 10 && n < 300) begin @(negedge clk); n++; end
      chk("midshift_edges", shift_edges - e0, 10);
    end
    reset_n = 1'b0;
    #1;
    chk("midshift_reset_pins", {24'h0, req_ready, rsp_valid, avr_si, avr_clk, avr_sreg_en,
                                avr_ce, avr_oe, avr_we}, 32'h8F);
    chk("midshift_partial", {22'h0, cpld_reg[9:0]}, {22'h0, tmp_a[20:11]});
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, tmp_a, 8'h00, lat, rd, edges, wec, oec, web);
    chk("post_reset_latency", lat, LAT_FULL);
    chk("post_reset_edges", edges, ADDR_W);
    chk("post_reset_cpld", {11'h0, cpld_reg}, {11'h0, tmp_a});
    chk("post_reset_rdata", {24'h0, rd}, {24'h0, dflt(tmp_a)});

    // req_valid held high across three requests
    begin
      int acc [3];
      int nacc, nrsp, cyc, w0;
      logic pre_ready;
      nacc = 0; nrsp = 0; cyc = 0; w0 = we_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h055555; req_wdata = 8'h77;
      mon_wd = 8'h77;
      while (nrsp < 3 && cyc < 400) begin
        @(negedge clk); pre_ready = req_ready;
        @(posedge clk); cyc++;
        if (pre_ready) begin
          if (nacc < 3) acc[nacc] = cyc;
          nacc++;
        end
        #1;
        if (rsp_valid) nrsp++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_accepts", nacc, 3);
      chk("b2b_responses", nrsp, 3);
      chk("b2b_gap_full", acc[1] - acc[0], LAT_FULL + 2);
      chk("b2b_gap_skip", acc[2] - acc[1], LAT_SKIP + 2);
      chk("b2b_we_cycles", we_cnt - w0, 3 * STROBE_CYC);
    end

    // random traffic against the transaction-level model
    ref_last_valid = 1'b1;
    ref_last_addr  = 21'h055555;
    for (int i = 0; i < 4; i++) pool[i] = 21'h120000 + ADDR_W'(i) * 21'h01111;
    for (int k = 0; k < 30; k++) begin
      logic w, hit;
      logic [ADDR_W-1:0] a;
      logic [7:0] d, exp_rd;
      w = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 3)];
      d = 8'($urandom);
      hit = ref_last_valid && (a == ref_last_addr);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(w, a, d, lat, rd, edges, wec, oec, web);
      chk($sformatf("r%0d_latency", k), lat, hit ? LAT_SKIP : LAT_FULL);
      chk($sformatf("r%0d_edges", k), edges, hit ? 0 : ADDR_W);
      chk($sformatf("r%0d_cpld", k), {11'h0, cpld_reg}, {11'h0, a});
      if (w) begin
        chk($sformatf("r%0d_we_cycles", k), wec, STROBE_CYC);
        chk($sformatf("r%0d_wdata_bad", k), web, 0);
        ref_mem[a] = d;
      end else begin
        exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        chk($sformatf("r%0d_oe_cycles", k), oec, STROBE_CYC);
        chk($sformatf("r%0d_rdata", k), {24'h0, rd}, {24'h0, exp_rd});
      end
      ref_last_valid = 1'b1;
      ref_last_addr  = a;
    end

    chk("bus_invariants", inv_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
